// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the ccff configuration loader: register offsets,
// STATUS/CTRL bit positions and the shift-engine state encoding.
// No ports; imported by ccff_wb_loader and ccff_word_fifo.
package ccff_loader_pkg;

   // Word offsets, i.e. wbs_adr_i[4:2]
   localparam logic [2:0] OFF_CTRL    = 3'd0;
   localparam logic [2:0] OFF_STATUS  = 3'd1;
   localparam logic [2:0] OFF_BITCNT  = 3'd2;
   localparam logic [2:0] OFF_DATA    = 3'd3;
   localparam logic [2:0] OFF_TAILCAP = 3'd4;

   // CTRL bits
   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;

   // STATUS bits
   localparam int ST_BUSY     = 0;
   localparam int ST_DONE     = 1;
   localparam int ST_EMPTY    = 2;
   localparam int ST_FULL     = 3;
   localparam int ST_OVF      = 4;
   localparam int ST_UNDERRUN = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LOW,
      S_HIGH,
      S_DONE
   } state_e;

endpackage

// File: rtl/ccff_word_fifo.sv
// Purpose: synchronous word FIFO for bitstream words awaiting serialization.
// Latency: push visible at pop_dat_o the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i empties the
// FIFO (wins over push/pop); push_i/push_dat_i write; pop_i/pop_dat_o read
// (pop_dat_o is the head word, combinational); full_o/empty_o/count_o status.
module ccff_word_fifo
   import ccff_loader_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [W-1:0]             push_dat_i,
   input  logic                     pop_i,
   output logic [W-1:0]             pop_dat_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign pop_dat_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   // A pop frees a slot in the same cycle, so a push on a full FIFO is accepted then.
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
         else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/ccff_wb_loader.sv
// Purpose: Wishbone slave that serializes FIFO'd bitstream words MSB-first onto
// ccff_head with a generated prog_clk, capturing the last 32 ccff_tail bits.
// Latency: 1-cycle ack; bit period 2*CLK_DIV cycles. Backpressure: DATA push on full FIFO is acked and dropped (overflow).
// Ports: wb_clk_i/wb_rst_ni clock, async active-low reset; wbs_* Wishbone classic
// slave; prog_clk_o/ccff_head_o/ccff_tail_i configuration chain; busy_o/done_o status.
module ccff_wb_loader
   import ccff_loader_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned BITCNT_W   = 20,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        prog_clk_o,
   output logic        ccff_head_o,
   input  logic        ccff_tail_i,
   output logic        busy_o,
   output logic        done_o
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // ---------------- Wishbone decode ----------------
   logic        blk_sel, access, wr_en, rd_en;
   logic [2:0]  offset;
   logic        ctrl_wr, status_wr, bitcnt_wr, push_req;
   logic        start, abort;
   logic        ack_d, ack_q;
   logic [31:0] dat_d, dat_q, rdata;
   logic [31:0] bitcnt_merge;
   logic [BITCNT_W-1:0] bitcnt_d, bitcnt_q;
   logic        ovf_q;
   logic        unused_bits;

   assign blk_sel = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   // Suppressing access in the cycle after an ack both forces ack low there and
   // keeps a held strobe from acting twice back to back.
   assign access  = blk_sel & ~ack_q;
   assign wr_en   = access & wbs_we_i;
   assign rd_en   = access & ~wbs_we_i;
   assign offset  = wbs_adr_i[4:2];

   assign ctrl_wr   = wr_en & (offset == OFF_CTRL)   & wbs_sel_i[0];
   assign status_wr = wr_en & (offset == OFF_STATUS) & wbs_sel_i[0];
   assign bitcnt_wr = wr_en & (offset == OFF_BITCNT);
   assign push_req  = wr_en & (offset == OFF_DATA)   & (wbs_sel_i == 4'hF);
   assign start     = ctrl_wr & wbs_dat_i[CTRL_START];
   assign abort     = ctrl_wr & wbs_dat_i[CTRL_ABORT];

   assign unused_bits = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], bitcnt_merge};

   // ---------------- FIFO ----------------
   logic              fifo_pop, fifo_full, fifo_empty;
   logic [31:0]       fifo_dat;
   logic [CNT_W-1:0]  fifo_count;
   state_e            state_q;

   assign fifo_pop = (state_q == S_LOAD) & ~fifo_empty & ~abort;

   ccff_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (32)
   ) u_fifo (
      .clk_i      (wb_clk_i),
      .rst_ni     (wb_rst_ni),
      .flush_i    (abort),
      .push_i     (push_req),
      .push_dat_i (wbs_dat_i),
      .pop_i      (fifo_pop),
      .pop_dat_o  (fifo_dat),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   // ---------------- Shift engine state ----------------
   logic [BITCNT_W-1:0] remaining_q;
   logic [4:0]          bitidx_q;
   logic [31:0]         shreg_q;
   logic [DIV_W-1:0]    div_q;
   logic                prog_clk_q, head_q, busy_q, done_q, underrun_q;
   logic [31:0]         tailcap_q;

   // ---------------- Register file ----------------
   always_comb begin
      bitcnt_merge = 32'(bitcnt_q);
      for (int b = 0; b < 4; b++) begin
         if (wbs_sel_i[b]) bitcnt_merge[8*b +: 8] = wbs_dat_i[8*b +: 8];
      end
      bitcnt_d = bitcnt_q;
      if (bitcnt_wr) bitcnt_d = bitcnt_merge[BITCNT_W-1:0];
   end

   always_comb begin
      rdata = '0;
      unique case (offset)
         OFF_STATUS: begin
            rdata[ST_BUSY]     = busy_q;
            rdata[ST_DONE]     = done_q;
            rdata[ST_EMPTY]    = fifo_empty;
            rdata[ST_FULL]     = fifo_full;
            rdata[ST_OVF]      = ovf_q;
            rdata[ST_UNDERRUN] = underrun_q;
         end
         OFF_BITCNT:  rdata = 32'(bitcnt_q);
         OFF_DATA:    rdata = 32'(fifo_count);
         OFF_TAILCAP: rdata = tailcap_q;
         default:     rdata = '0;
      endcase
   end

   assign ack_d = access;
   assign dat_d = rd_en ? rdata : 32'h0;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         bitcnt_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         bitcnt_q <= bitcnt_d;
         // A dropped push in the same cycle as the W1C keeps the flag set.
         if (push_req && fifo_full && !fifo_pop) ovf_q <= 1'b1;
         else if (status_wr && wbs_dat_i[ST_OVF]) ovf_q <= 1'b0;
      end
   end

   // ---------------- Serializer FSM ----------------
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         bitidx_q    <= '0;
         shreg_q     <= '0;
         div_q       <= '0;
         prog_clk_q  <= 1'b0;
         head_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         underrun_q  <= 1'b0;
         tailcap_q   <= '0;
      end else begin
         // W1C first so that a completion in the same cycle still sets done.
         if (status_wr && wbs_dat_i[ST_DONE]) done_q <= 1'b0;

         if (abort) begin
            state_q    <= S_IDLE;
            prog_clk_q <= 1'b0;
            head_q     <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            div_q      <= '0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (start) begin
                     if (bitcnt_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q     <= S_LOAD;
                        done_q      <= 1'b0;
                        remaining_q <= bitcnt_q;
                        busy_q      <= 1'b1;
                        tailcap_q   <= '0;
                     end
                  end
               end
               S_LOAD: begin
                  if (!fifo_empty) begin
                     shreg_q    <= fifo_dat;
                     bitidx_q   <= 5'd31;
                     head_q     <= fifo_dat[31];
                     div_q      <= '0;
                     underrun_q <= 1'b0;
                     state_q    <= S_LOW;
                  end else begin
                     underrun_q <= 1'b1;
                  end
               end
               S_LOW: begin
                  if (div_q == DIV_LAST) begin
                     div_q       <= '0;
                     prog_clk_q  <= 1'b1;
                     state_q     <= S_HIGH;
                     // Sampled on the edge that raises prog_clk, i.e. before the
                     // chain reacts to it, so this is the bit it presented last period.
                     tailcap_q   <= {tailcap_q[30:0], ccff_tail_i};
                     remaining_q <= remaining_q - BITCNT_W'(1);
                  end else begin
                     div_q <= div_q + DIV_W'(1);
                  end
               end
               S_HIGH: begin
                  if (div_q == DIV_LAST) begin
                     div_q      <= '0;
                     prog_clk_q <= 1'b0;
                     if (remaining_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                     end else if (bitidx_q == 5'd0) begin
                        state_q <= S_LOAD;
                     end else begin
                        bitidx_q <= bitidx_q - 5'd1;
                        head_q   <= shreg_q[bitidx_q - 5'd1];
                        state_q  <= S_LOW;
                     end
                  end else begin
                     div_q <= div_q + DIV_W'(1);
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign wbs_ack_o   = ack_q;
   assign wbs_dat_o   = dat_q;
   assign prog_clk_o  = prog_clk_q;
   assign ccff_head_o = head_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_ccff_wb_loader.sv
module tb_ccff_wb_loader;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] dat_i = '0, adr = '0;
   logic        ack;
   logic [31:0] dat_o;
   logic        prog_clk, head, tail_q, busy, done;

   int nvec = 0;
   int nerr = 0;

   // Monitor of prog_clk rising edges
   int          pulses = 0;
   logic [63:0] hbits = '0;
   time         t_last = 0;
   time         period = 0;

   always #5 clk = ~clk;

   ccff_wb_loader dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .wbs_stb_i   (stb),
      .wbs_cyc_i   (cyc),
      .wbs_we_i    (we),
      .wbs_sel_i   (sel),
      .wbs_dat_i   (dat_i),
      .wbs_adr_i   (adr),
      .wbs_ack_o   (ack),
      .wbs_dat_o   (dat_o),
      .prog_clk_o  (prog_clk),
      .ccff_head_o (head),
      .ccff_tail_i (tail_q),
      .busy_o      (busy),
      .done_o      (done)
   );

   // One-stage chain model: head looped back to tail through a prog_clk flop.
   always @(posedge prog_clk or negedge rst_n) begin
      if (!rst_n) tail_q <= 1'b0;
      else        tail_q <= head;
   end

   always @(posedge prog_clk) begin
      pulses <= pulses + 1;
      hbits  <= {hbits[62:0], head};
      period <= $time - t_last;
      t_last <= $time;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r);
      logic got;
      got = 1'b0;
      r = '0;
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            r = dat_o;
            got = 1'b1;
            break;
         end
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
      check("wb_ack", 64'(got), 64'd1);
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d);
      logic [31:0] rd_unused;
      xfer(1'b1, BASE + 32'(off), d, 4'hF, rd_unused);
   endtask

   task automatic rd(input logic [7:0] off, output logic [31:0] r);
      xfer(1'b0, BASE + 32'(off), 32'h0, 4'hF, r);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         n++;
         if (done) break;
      end
      check("done_wait", 64'(done), 64'd1);
   endtask

   task automatic wait_pulses(input int target);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (pulses >= target) break;
      end
      check("pulse_wait", 64'(pulses >= target), 64'd1);
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] rd_unused;
      int n;
      int base;
      int acks;

      // ---- Reset ----
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 64'({ack, dat_o, prog_clk, head, busy, done}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rd(8'h04, r);
      check("reset_status", 64'(r), 64'h4);

      // ---- Tail capture: 32 bits of 0x12345678 through the loopback ----
      wr(8'h08, 32'd32);
      wr(8'h0C, 32'h1234_5678);
      base = pulses;
      wr(8'h00, 32'h1);
      wait_done(n);
      check("tail_done_cycles", 64'(n), 64'd129);
      check("tail_pulses", 64'(pulses - base), 64'd32);
      check("tail_head_bits", 64'(hbits[31:0]), 64'h1234_5678);
      check("tail_period", 64'(period), 64'd40);
      rd(8'h10, r);
      check("tailcap", 64'(r), 64'h091A_2B3C);
      @(posedge clk); #1;
      check("dat_o_idle", 64'({ack, dat_o}), 64'd0);
      rd(8'h04, r);
      check("tail_status", 64'(r), 64'h6);

      // ---- Basic 8-bit load ----
      wr(8'h08, 32'd8);
      wr(8'h0C, 32'hA500_0000);
      base = pulses;
      wr(8'h00, 32'h1);
      wait_done(n);
      check("basic_done_cycles", 64'(n), 64'd33);
      check("basic_pulses", 64'(pulses - base), 64'd8);
      check("basic_head_bits", 64'(hbits[7:0]), 64'hA5);
      check("basic_period", 64'(period), 64'd40);
      check("basic_busy", 64'(busy), 64'd0);
      rd(8'h10, r);
      check("basic_tailcap", 64'(r), 64'h52);
      rd(8'h04, r);
      check("basic_status", 64'(r), 64'h6);

      // ---- Byte selects, unmapped, out of window, held strobe ----
      wr(8'h08, 32'h0);
      xfer(1'b1, BASE + 32'h08, 32'hFFFF_FFFF, 4'b0010, rd_unused);
      rd(8'h08, r);
      check("bitcnt_byte1", 64'(r), 64'h0000_FF00);
      xfer(1'b1, BASE + 32'h08, 32'hFFFF_FFFF, 4'b0100, rd_unused);
      rd(8'h08, r);
      check("bitcnt_byte2_trunc", 64'(r), 64'h000F_FF00);
      wr(8'h14, 32'hFFFF_FFFF);
      rd(8'h14, r);
      check("unmapped_read", 64'(r), 64'h0);
      rd(8'h00, r);
      check("ctrl_read", 64'(r), 64'h0);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h100;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      check("out_of_window_acks", 64'(acks), 64'd0);
      adr = BASE + 32'h04;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      stb = 1'b0; cyc = 1'b0; sel = 4'h0;
      check("held_strobe_acks", 64'(acks), 64'd2);

      // ---- Multi-word with underrun ----
      wr(8'h08, 32'd40);
      wr(8'h0C, 32'h8000_0001);
      xfer(1'b1, BASE + 32'h0C, 32'hDEAD_BEEF, 4'h7, rd_unused);
      rd(8'h0C, r);
      check("partial_sel_push_ignored", 64'(r), 64'd1);
      base = pulses;
      wr(8'h00, 32'h1);
      repeat (200) @(posedge clk);
      #1;
      check("underrun_pulses", 64'(pulses - base), 64'd32);
      check("underrun_prog_clk", 64'(prog_clk), 64'd0);
      rd(8'h04, r);
      check("underrun_status", 64'(r), 64'h25);
      wr(8'h0C, 32'hC300_0000);
      wait_done(n);
      check("multi_pulses", 64'(pulses - base), 64'd40);
      check("multi_head_bits", 64'(hbits[39:0]), 64'h80_0000_01C3);
      rd(8'h10, r);
      check("multi_tailcap", 64'(r), 64'h0000_00E1);
      rd(8'h04, r);
      check("multi_status", 64'(r), 64'h6);

      // ---- Overflow ----
      wr(8'h04, 32'h2);
      rd(8'h04, r);
      check("done_w1c", 64'(r), 64'h4);
      for (int i = 1; i <= 5; i++) wr(8'h0C, {8{4'(i)}});
      rd(8'h0C, r);
      check("fifo_count_full", 64'(r), 64'd4);
      rd(8'h04, r);
      check("overflow_status", 64'(r), 64'h18);
      wr(8'h04, 32'h10);
      rd(8'h04, r);
      check("overflow_w1c", 64'(r), 64'h08);

      // ---- Abort after 5 pulses ----
      wr(8'h08, 32'd100);
      base = pulses;
      wr(8'h00, 32'h1);
      wait_pulses(base + 5);
      wr(8'h00, 32'h2);
      check("abort_outputs", 64'({busy, prog_clk, head}), 64'd0);
      rd(8'h04, r);
      check("abort_status", 64'(r), 64'h4);
      base = pulses;
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_pulses", 64'(pulses - base), 64'd0);

      // ---- Abort and start together: abort wins ----
      wr(8'h0C, 32'hFFFF_FFFF);
      wr(8'h00, 32'h3);
      check("abort_start_busy", 64'(busy), 64'd0);
      rd(8'h04, r);
      check("abort_start_status", 64'(r), 64'h4);

      // ---- BITCNT=0 start ----
      wr(8'h08, 32'd0);
      base = pulses;
      wr(8'h00, 32'h1);
      check("zero_len_done", 64'({done, busy}), 64'b10);
      repeat (10) @(posedge clk);
      #1;
      check("zero_len_pulses", 64'(pulses - base), 64'd0);
      rd(8'h04, r);
      check("zero_len_status", 64'(r), 64'h6);

      // ---- Asynchronous reset mid-shift ----
      wr(8'h08, 32'd8);
      wr(8'h0C, 32'hFF00_0000);
      wr(8'h00, 32'h1);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (prog_clk) break;
      end
      check("midshift_high", 64'(prog_clk), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", 64'({ack, dat_o, prog_clk, head, busy, done}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
